rom_dl_sequencer: RTL and testbench

// - Front end of the ROM download path. Sits between the HPS ioctl stream and the ROM selector / dual-port ROM banks, all in the CLK_DL domain.
// - Registers each ioctl byte into a one-cycle write strobe with its address and data; these drive ADDR_DL, DATA_IN and WR on every ROM bank.
// - Checks that addresses are contiguous and that the total length is correct.
// - Holds the game core in reset until a complete, valid image has loaded.

---
 rtl/rom_dl_sequencer.sv | 137 +++++++++++++
 tb/tb_rom_dl_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// ============================================================================
// Module  : rom_dl_sequencer
// Brief   : ROM download front end; turns the ioctl byte stream into ROM bank
//           write strobes, checks contiguity/length, gates the core reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX      = 8'h00,
  parameter logic [24:0] EXPECTED_BYTES = 25'hA0200,
  parameter int          FLUSH_CYCLES   = 4
) (
  input  logic        CLK_DL,
  input  logic        RESET_N,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic        IOCTL_WR,
  input  logic [24:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DOUT,
  output logic [24:0] DL_ADDR,
  output logic [7:0]  DL_DATA,
  output logic        DL_WR,
  output logic [24:0] BYTE_COUNT,
  output logic        ROM_BUSY,
  output logic        ROM_OK,
  output logic        ROM_ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [24:0] COUNT_MAX  = '1;

  state_t      state, state_nxt;
  logic        match, match_d, dl_rise, start;
  logic        accept, in_range;
  logic [3:0]  flush_cnt, flush_cnt_nxt;
  logic        addr_err, addr_err_nxt, err_base;
  logic [24:0] byte_count, byte_count_nxt, count_base;

  always_comb begin
    match    = IOCTL_DOWNLOAD && (IOCTL_INDEX == ROM_INDEX);
    dl_rise  = match && !match_d;
    // A new load may only begin from a resting state; a rise during FLUSH is ignored.
    start    = dl_rise && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    accept   = IOCTL_WR && ((state == S_LOAD) || start);
    in_range = IOCTL_ADDR < EXPECTED_BYTES;
    count_base = start ? '0 : byte_count;
    err_base   = start ? 1'b0 : addr_err;
  end

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    byte_count_nxt = count_base;
    addr_err_nxt   = err_base;

    if (accept) begin
      if (count_base != COUNT_MAX)
        byte_count_nxt = count_base + 25'd1;
      if (!in_range || (IOCTL_ADDR != count_base))
        addr_err_nxt = 1'b1;
    end

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start)
          state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!match) begin
          state_nxt     = S_FLUSH;
          flush_cnt_nxt = FLUSH_INIT;
        end
      end
      S_FLUSH: begin
        flush_cnt_nxt = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) begin
          flush_cnt_nxt = '0;
          if ((byte_count == EXPECTED_BYTES) && !addr_err)
            state_nxt = S_DONE;
          else
            state_nxt = S_ERROR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_DL or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      match_d    <= 1'b0;
      flush_cnt  <= '0;
      addr_err   <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_nxt;
      match_d    <= match;
      flush_cnt  <= flush_cnt_nxt;
      addr_err   <= addr_err_nxt;
      byte_count <= byte_count_nxt;
    end
  end

  // Out-of-range bytes are counted but never reach the banks.
  always_ff @(posedge CLK_DL or negedge RESET_N) begin
    if (!RESET_N) begin
      DL_WR   <= 1'b0;
      DL_ADDR <= '0;
      DL_DATA <= '0;
    end else begin
      DL_WR <= accept && in_range;
      if (accept && in_range) begin
        DL_ADDR <= IOCTL_ADDR;
        DL_DATA <= IOCTL_DOUT;
      end
    end
  end

  always_comb begin
    BYTE_COUNT = byte_count;
    ROM_BUSY   = (state != S_DONE);
    ROM_OK     = (state == S_DONE);
    ROM_ERR    = (state == S_ERROR);
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_dl_sequencer.sv
// ============================================================================
// Module  : tb_rom_dl_sequencer
// Brief   : Scoreboard bench for rom_dl_sequencer with a scaled image length.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_dl_sequencer;

  localparam logic [24:0] EXP  = 25'h180;
  localparam int          F    = 4;
  localparam int          NONE = 1 << 20;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        IOCTL_DOWNLOAD;
  logic [7:0]  IOCTL_INDEX;
  logic        IOCTL_WR;
  logic [24:0] IOCTL_ADDR;
  logic [7:0]  IOCTL_DOUT;
  logic [24:0] DL_ADDR;
  logic [7:0]  DL_DATA;
  logic        DL_WR;
  logic [24:0] BYTE_COUNT;
  logic        ROM_BUSY, ROM_OK, ROM_ERR;

  rom_dl_sequencer #(
    .ROM_INDEX      (8'h00),
    .EXPECTED_BYTES (EXP),
    .FLUSH_CYCLES   (F)
  ) dut (
    .CLK_DL         (clk),
    .RESET_N        (RESET_N),
    .IOCTL_DOWNLOAD (IOCTL_DOWNLOAD),
    .IOCTL_INDEX    (IOCTL_INDEX),
    .IOCTL_WR       (IOCTL_WR),
    .IOCTL_ADDR     (IOCTL_ADDR),
    .IOCTL_DOUT     (IOCTL_DOUT),
    .DL_ADDR        (DL_ADDR),
    .DL_DATA        (DL_DATA),
    .DL_WR          (DL_WR),
    .BYTE_COUNT     (BYTE_COUNT),
    .ROM_BUSY       (ROM_BUSY),
    .ROM_OK         (ROM_OK),
    .ROM_ERR        (ROM_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [24:0] last_addr = '0;
  logic [7:0]  last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every DL_WR pulse must match the head of the queue, in address, data and cycle.
  always @(negedge clk) begin
    if (!RESET_N) begin
      last_addr = '0;
      last_data = '0;
    end else if (DL_WR) begin
      if (q.size() == 0) begin
        check("dl_wr_spurious", {7'd0, DL_ADDR}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dl_addr", {7'd0, DL_ADDR}, {7'd0, e.addr});
        check("dl_data", {24'd0, DL_DATA}, {24'd0, e.data});
        check("dl_cycle", cyc, e.cyc);
        last_addr = e.addr;
        last_data = e.data;
      end
    end else begin
      check("dl_hold", {DL_DATA, DL_ADDR[23:0]}, {last_data, last_addr[23:0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [24:0] a, input bit expect_wr);
    exp_t e;
    IOCTL_WR   = 1'b1;
    IOCTL_ADDR = a;
    IOCTL_DOUT = a[7:0];
    if (expect_wr) begin
      e.cyc  = cyc + 1;
      e.addr = a;
      e.data = a[7:0];
      q.push_back(e);
    end
    tick();
  endtask

  // Streams n bytes at addresses 0.. with address `skip` jumped over; the first byte
  // rides the same cycle as the download rise.
  task automatic load(input logic [7:0] idx, input int n, input int skip, input bit exp_ok);
    bit matched;
    logic [24:0] a;
    matched        = (idx == 8'h00);
    IOCTL_DOWNLOAD = 1'b1;
    IOCTL_INDEX    = idx;
    for (int i = 0; i < n; i++) begin
      a = 25'(i) + ((i >= skip) ? 25'd1 : 25'd0);
      drive_byte(a, matched && (a < EXP));
    end
    IOCTL_WR       = 1'b0;
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    if (matched) begin
      check("busy_in_flush", {31'd0, ROM_BUSY}, 32'd1);
      check("ok_in_flush", {31'd0, ROM_OK}, 32'd0);
      check("byte_count", {7'd0, BYTE_COUNT}, n);
      repeat (F - 1) tick();
      check("ok_before_flush_end", {31'd0, ROM_OK | ROM_ERR}, 32'd0);
      tick();
      check("rom_ok", {31'd0, ROM_OK}, {31'd0, exp_ok});
      check("rom_err", {31'd0, ROM_ERR}, {31'd0, !exp_ok});
      check("rom_busy", {31'd0, ROM_BUSY}, {31'd0, !exp_ok});
    end
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N        = 1'b0;
    IOCTL_DOWNLOAD = 1'b0;
    IOCTL_INDEX    = 8'h00;
    IOCTL_WR       = 1'b0;
    IOCTL_ADDR     = '0;
    IOCTL_DOUT     = '0;
    repeat (3) tick();
    check("rst_busy", {31'd0, ROM_BUSY}, 32'd1);
    check("rst_ok", {31'd0, ROM_OK}, 32'd0);
    check("rst_err", {31'd0, ROM_ERR}, 32'd0);
    check("rst_count", {7'd0, BYTE_COUNT}, 32'd0);
    check("rst_dl_wr", {31'd0, DL_WR}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) tick();

    // Full contiguous image from IDLE.
    load(8'h00, int'(EXP), NONE, 1'b1);

    // Foreign index while DONE: no writes, status untouched.
    load(8'h01, 100, NONE, 1'b0);
    check("t5_ok", {31'd0, ROM_OK}, 32'd1);
    check("t5_busy", {31'd0, ROM_BUSY}, 32'd0);
    check("t5_count", {7'd0, BYTE_COUNT}, {7'd0, EXP});

    // Short image.
    load(8'h00, int'(EXP) - 1, NONE, 1'b0);

    // Gap at 0x80 with length padded to EXP; last address lands out of range.
    load(8'h00, int'(EXP), 'h80, 1'b0);

    // Final byte written at EXP instead of EXP-1.
    load(8'h00, int'(EXP), int'(EXP) - 1, 1'b0);

    // Reset mid-load.
    IOCTL_DOWNLOAD = 1'b1;
    IOCTL_INDEX    = 8'h00;
    for (int i = 0; i < 'h50; i++) drive_byte(25'(i), 1'b1);
    IOCTL_WR = 1'b0;
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_busy", {31'd0, ROM_BUSY}, 32'd1);
    check("t6_ok_err", {30'd0, ROM_OK, ROM_ERR}, 32'd0);
    check("t6_count", {7'd0, BYTE_COUNT}, 32'd0);
    check("t6_dl_addr", {7'd0, DL_ADDR}, 32'd0);
    check("t6_dl_data", {24'd0, DL_DATA}, 32'd0);
    IOCTL_DOWNLOAD = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    load(8'h00, int'(EXP), NONE, 1'b1);

    repeat (3) tick();
    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
